// File: rtl/mult_pkg.sv
// Shared definitions for the sequential arithmetic blocks: FSM states,
// step-count helper and the operand magnitude helper.
package mult_pkg;

   localparam int unsigned MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int unsigned nsteps(input int unsigned width, input int unsigned radix_bits);
      return width / radix_bits;
   endfunction

   // Magnitude of a w-bit operand; negation applies only to signed negatives.
   function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x,
                                                input int unsigned    w,
                                                input logic           sgn);
      logic [MAX_W-1:0] mask;
      logic             msb;
      mask = (MAX_W'(1) << w) - MAX_W'(1);
      msb  = 1'(x >> (w - 1));
      return (sgn && msb) ? ((-x) & mask) : (x & mask);
   endfunction

endpackage

// File: rtl/pp_digit_gen.sv
// Combinational a_mag x digit partial product: AND-array bits summed per
// column, then the column sums are weighted and accumulated.
module pp_digit_gen #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned RADIX_BITS = 2
) (
   input  logic [WIDTH-1:0]            a_mag,
   input  logic [RADIX_BITS-1:0]       digit,
   output logic [WIDTH+RADIX_BITS-1:0] pp
);

   localparam int unsigned PW = WIDTH + RADIX_BITS;

   logic [PW-1:0] chain [PW+1];

   assign chain[0] = '0;

   for (genvar c = 0; c < PW; c++) begin : g_col
      logic [RADIX_BITS-1:0] col_bits;
      for (genvar j = 0; j < RADIX_BITS; j++) begin : g_row
         if ((c >= j) && (c - j < WIDTH)) begin : g_in
            assign col_bits[j] = a_mag[c-j] & digit[j];
         end else begin : g_out
            assign col_bits[j] = 1'b0;
         end
      end
      assign chain[c+1] = chain[c] + (PW'($countones(col_bits)) << c);
   end

   assign pp = chain[PW];

endmodule

// File: rtl/seq_radix_multiplier.sv
// Iterative multiplier: RADIX_BITS of B per cycle, fixed NSTEPS latency,
// valid/ready on both sides, unsigned or two's-complement per operation.
module seq_radix_multiplier
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned RADIX_BITS = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p,
   output logic                 busy
);

   localparam int unsigned NSTEPS = nsteps(WIDTH, RADIX_BITS);
   localparam int unsigned PW2    = 2 * WIDTH;
   localparam int unsigned PPW    = WIDTH + RADIX_BITS;
   localparam int unsigned SW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

   if ((WIDTH < 2) || (RADIX_BITS == 0) || (RADIX_BITS > WIDTH) ||
       (WIDTH % RADIX_BITS != 0) || (WIDTH > MAX_W)) begin : g_bad_cfg
      $error("seq_radix_multiplier: illegal WIDTH/RADIX_BITS combination");
   end

   state_e           state_q, state_d;
   logic [PW2-1:0]   acc_q, acc_d;
   logic [SW-1:0]    step_q, step_d;
   logic [WIDTH-1:0] a_mag_q, a_mag_d;
   logic [WIDTH-1:0] b_mag_q, b_mag_d;
   logic             neg_q, neg_d;
   logic [PW2-1:0]   p_q, p_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   logic [RADIX_BITS-1:0] digit_c;
   logic [PPW-1:0]        pp_c;
   logic [31:0]           shamt_c;
   logic [PW2-1:0]        acc_sum_c;
   logic                  last_c;

   assign shamt_c   = 32'(step_q) * RADIX_BITS;
   assign digit_c   = RADIX_BITS'(b_mag_q >> shamt_c);
   assign acc_sum_c = acc_q + (PW2'(pp_c) << shamt_c);
   assign last_c    = (step_q == SW'(NSTEPS - 1));

   pp_digit_gen #(
      .WIDTH      (WIDTH),
      .RADIX_BITS (RADIX_BITS)
   ) u_pp_digit_gen (
      .a_mag (a_mag_q),
      .digit (digit_c),
      .pp    (pp_c)
   );

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      step_d      = step_q;
      a_mag_d     = a_mag_q;
      b_mag_d     = b_mag_q;
      neg_d       = neg_q;
      p_d         = p_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_mag_d = WIDTH'(abs_val(MAX_W'(a), WIDTH, signed_mode));
               b_mag_d = WIDTH'(abs_val(MAX_W'(b), WIDTH, signed_mode));
               neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_d   = '0;
               step_d  = '0;
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d  = acc_sum_c;
            step_d = step_q + SW'(1);
            if (last_c) begin
               p_d         = neg_q ? (-acc_sum_c) : acc_sum_c;
               out_valid_d = 1'b1;
               step_d      = '0;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         step_q      <= '0;
         a_mag_q     <= '0;
         b_mag_q     <= '0;
         neg_q       <= 1'b0;
         p_q         <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         step_q      <= step_d;
         a_mag_q     <= a_mag_d;
         b_mag_q     <= b_mag_d;
         neg_q       <= neg_d;
         p_q         <= p_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign p         = p_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_seq_radix_multiplier.sv
// Self-checking bench: latency/product model plus directed hand-computed vectors.
module tb_seq_radix_multiplier;

   localparam int unsigned W      = 8;
   localparam int unsigned R      = 2;
   localparam int          NSTEPS = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          signed_mode;
   logic          out_valid;
   logic          out_ready;
   logic [2*W-1:0] p;
   logic          busy;

   int n_chk  = 0;
   int n_fail = 0;

   seq_radix_multiplier #(.WIDTH(W), .RADIX_BITS(R)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .p           (p),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [2*W-1:0] golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sm);
      logic signed [2*W-1:0] sx, sy;
      if (sm) begin
         sx = {{W{x[W-1]}}, x};
         sy = {{W{y[W-1]}}, y};
         return 16'(sx * sy);
      end
      return 16'({8'b0, x} * {8'b0, y});
   endfunction

   // Transaction-level model: accept when idle, result NSTEPS edges later,
   // held until taken.
   logic          m_busy, m_valid;
   int            m_cnt;
   logic [2*W-1:0] m_p, m_pend;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  = 1'b0;
         m_valid = 1'b0;
         m_cnt   = 0;
         m_p     = '0;
         m_pend  = '0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy = 1'b1;
            m_cnt  = NSTEPS;
            m_pend = golden(a, b, signed_mode);
         end
      end else if (!m_valid) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) begin
            m_valid = 1'b1;
            m_p     = m_pend;
         end
      end else if (out_ready) begin
         m_valid = 1'b0;
         m_busy  = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("in_ready", 32'(in_ready), 32'(!m_busy));
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         chk("busy", 32'(busy), 32'(m_busy));
         chk("p", 32'(p), 32'(m_p));
      end
   end

   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic sm,
                        input int hold, input bit lit, input logic [2*W-1:0] exp_p,
                        input bit scramble);
      int n;
      @(negedge clk);
      a = ta; b = tb2; signed_mode = sm; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      if (scramble) begin
         signed_mode = ~sm;
         a = W'($urandom);
         b = W'($urandom);
      end
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 32'(n), 32'(NSTEPS));
      if (lit) chk("p_literal", 32'(p), 32'(exp_p));
      for (int i = 0; i < hold; i++) begin
         in_valid = i[0];
         a = W'($urandom);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (lit) chk("p_after_take", 32'(p), 32'(exp_p));
      chk("idle_after_take", 32'(in_ready), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b0;
      #12;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_p", 32'(p), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(8'd13,  8'd11,  1'b0, 0, 1'b1, 16'd143,   1'b0);
      do_op(8'hFD,  8'h05,  1'b1, 0, 1'b1, 16'hFFF1,  1'b0);
      do_op(8'h80,  8'h80,  1'b1, 1, 1'b1, 16'h4000,  1'b0);
      do_op(8'h80,  8'h7F,  1'b1, 0, 1'b1, 16'hC080,  1'b0);
      do_op(8'hFD,  8'h05,  1'b0, 0, 1'b1, 16'd1265,  1'b1);
      do_op(8'hFF,  8'hFF,  1'b0, 0, 1'b1, 16'hFE01,  1'b0);
      do_op(8'hFF,  8'hFF,  1'b1, 0, 1'b1, 16'h0001,  1'b0);
      do_op(8'h00,  8'h9C,  1'b1, 0, 1'b1, 16'h0000,  1'b0);
      // Backpressure with ignored in_valid pulses while the result waits
      do_op(8'd25,  8'd10,  1'b0, 6, 1'b1, 16'd250,   1'b0);

      // Asynchronous reset during CALC step 2
      @(negedge clk);
      a = 8'd200; b = 8'd3; signed_mode = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_p", 32'(p), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(8'd7, 8'd9, 1'b0, 0, 1'b1, 16'd63, 1'b0);

      for (int k = 0; k < 80; k++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
               1'b0, '0, 1'($urandom));
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
